// File: rtl/sub_bytes_scheduler_pkg.sv
// Shared AES definitions for the SubBytes scheduler: FSM states, grant tags and
// the FIPS-197 forward/inverse S-box tables.
package sub_bytes_scheduler_pkg;

  typedef enum logic [1:0] {IDLE, ST_BUSY, KEY_BUSY, DONE} sched_state_t;
  typedef enum logic {STATE, KEY} grant_t;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

endpackage

// File: rtl/sub_bytes_scheduler_sub_word.sv
// The single shared substitution lane: four byte-wise S-box lookups on one
// 32-bit word, forward or inverse selected at elaboration.
module sub_word
  import sub_bytes_scheduler_pkg::*;
#(
  parameter int INVERSE = 0
) (
  input  logic [31:0] i_word,
  output logic [31:0] o_word
);

  for (genvar i = 0; i < 4; i++) begin : g_byte
    assign o_word[8*i +: 8] = (INVERSE != 0) ? INV_SBOX[i_word[8*i +: 8]]
                                             : SBOX[i_word[8*i +: 8]];
  end

endmodule

// File: rtl/sub_bytes_scheduler.sv
// Arbitrates the AES datapath (128-bit state) and key schedule (32-bit SubWord)
// onto one shared 32-bit S-box lane, round-robin on contention.
module sub_bytes_scheduler
  import sub_bytes_scheduler_pkg::*;
#(
  parameter int INVERSE = 0
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         st_valid,
  output logic         st_ready,
  input  logic [127:0] st_in,
  input  logic         key_valid,
  output logic         key_ready,
  input  logic [31:0]  key_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         out_is_key
);

  sched_state_t r_state;
  grant_t       r_last_grant;
  logic [1:0]   r_cnt;
  logic [127:0] r_data;
  logic         r_out_valid;
  logic         r_is_key;

  logic         w_grant_st;
  logic         w_grant_key;
  logic [31:0]  w_lane_in;
  logic [31:0]  w_lane_out;

  // Ready is combinational from the requests so a grant can happen on the very
  // first edge after reset; it is masked while reset is held.
  always_comb begin
    w_grant_st  = 1'b0;
    w_grant_key = 1'b0;
    if ((r_state == IDLE) && !reset) begin
      if (st_valid && key_valid) begin
        w_grant_st  = (r_last_grant == KEY);
        w_grant_key = (r_last_grant == STATE);
      end else begin
        w_grant_st  = st_valid;
        w_grant_key = key_valid;
      end
    end
  end

  always_comb begin
    w_lane_in = r_data[31:0];
    if (r_state == ST_BUSY) begin
      case (r_cnt)
        2'd0:    w_lane_in = r_data[127:96];
        2'd1:    w_lane_in = r_data[95:64];
        2'd2:    w_lane_in = r_data[63:32];
        default: w_lane_in = r_data[31:0];
      endcase
    end
  end

  sub_word #(.INVERSE(INVERSE)) u_lane (
    .i_word (w_lane_in),
    .o_word (w_lane_out)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_last_grant <= KEY;
      r_cnt        <= 2'd0;
      r_data       <= '0;
      r_out_valid  <= 1'b0;
      r_is_key     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grant_st) begin
            r_data       <= st_in;
            r_cnt        <= 2'd0;
            r_last_grant <= STATE;
            r_state      <= ST_BUSY;
          end else if (w_grant_key) begin
            r_data       <= {96'b0, key_in};
            r_last_grant <= KEY;
            r_state      <= KEY_BUSY;
          end
        end
        ST_BUSY: begin
          case (r_cnt)
            2'd0:    r_data[127:96] <= w_lane_out;
            2'd1:    r_data[95:64]  <= w_lane_out;
            2'd2:    r_data[63:32]  <= w_lane_out;
            default: r_data[31:0]   <= w_lane_out;
          endcase
          // Leave the counter parked at 3 rather than wrapping into word 0.
          if (r_cnt == 2'd3) begin
            r_out_valid <= 1'b1;
            r_is_key    <= 1'b0;
            r_state     <= DONE;
          end else begin
            r_cnt <= r_cnt + 2'd1;
          end
        end
        KEY_BUSY: begin
          r_data[31:0] <= w_lane_out;
          r_out_valid  <= 1'b1;
          r_is_key     <= 1'b1;
          r_state      <= DONE;
        end
        default: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
      endcase
    end
  end

  assign st_ready   = w_grant_st;
  assign key_ready  = w_grant_key;
  assign out_valid  = r_out_valid;
  assign out_data   = r_data;
  assign out_is_key = r_is_key;

endmodule

// File: tb/tb_sub_bytes_scheduler.sv
// Self-checking bench: forward and inverse schedulers share stimulus; expected
// results come from an S-box built from GF(2^8) inversion plus the affine map.
module tb_sub_bytes_scheduler;

  logic         clock = 1'b0;
  logic         reset;
  logic         st_valid, key_valid, out_ready;
  logic [127:0] st_in;
  logic [31:0]  key_in;

  logic         st_ready, key_ready, out_valid, out_is_key;
  logic [127:0] out_data;
  logic         st_ready_i, key_ready_i, out_valid_i, out_is_key_i;
  logic [127:0] out_data_i;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] fwd_tab [256];
  logic [7:0] inv_tab [256];

  always #5 clock = ~clock;

  sub_bytes_scheduler #(.INVERSE(0)) dut (
    .clock(clock), .reset(reset),
    .st_valid(st_valid), .st_ready(st_ready), .st_in(st_in),
    .key_valid(key_valid), .key_ready(key_ready), .key_in(key_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_is_key(out_is_key)
  );

  sub_bytes_scheduler #(.INVERSE(1)) dut_inv (
    .clock(clock), .reset(reset),
    .st_valid(st_valid), .st_ready(st_ready_i), .st_in(st_in),
    .key_valid(key_valid), .key_ready(key_ready_i), .key_in(key_in),
    .out_valid(out_valid_i), .out_ready(out_ready),
    .out_data(out_data_i), .out_is_key(out_is_key_i)
  );

  initial begin
    #500000;
    $display("[TB] FAIL watchdog simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] aa = a;
    logic [7:0] bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] y8;
    if (a == 8'h00) return 8'h00;
    for (int y = 1; y < 256; y++) begin
      y8 = y[7:0];
      if (gmul(a, y8) == 8'h01) return y8;
    end
    return 8'h00;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  task automatic build_tables();
    logic [7:0] b, s, x8;
    for (int x = 0; x < 256; x++) begin
      x8 = x[7:0];
      b  = ginv(x8);
      s  = b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
      fwd_tab[x] = s;
      inv_tab[s] = x8;
    end
  endtask

  function automatic logic [127:0] exp_state(input logic [127:0] x, input bit inv);
    logic [127:0] r;
    for (int i = 0; i < 16; i++)
      r[8*i +: 8] = inv ? inv_tab[x[8*i +: 8]] : fwd_tab[x[8*i +: 8]];
    return r;
  endfunction

  function automatic logic [127:0] exp_key(input logic [31:0] w, input bit inv);
    logic [127:0] r = '0;
    for (int i = 0; i < 4; i++)
      r[8*i +: 8] = inv ? inv_tab[w[8*i +: 8]] : fwd_tab[w[8*i +: 8]];
    return r;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Drives one request, scrambles the input right after acceptance, and reports
  // the edges from accept to out_valid plus the captured results.
  task automatic applyStimulus(input bit is_key, input logic [127:0] data,
                               output int lat, output logic [127:0] d,
                               output logic [127:0] di, output logic k,
                               output bit timeout);
    int w;
    timeout = 1'b0;
    lat = 0;
    d = '0;
    di = '0;
    k = 1'b0;
    @(negedge clock);
    out_ready = 1'b0;
    if (is_key) begin
      key_valid = 1'b1;
      key_in = data[31:0];
    end else begin
      st_valid = 1'b1;
      st_in = data;
    end
    #1;
    w = 0;
    while (!(is_key ? key_ready : st_ready) && w < 20) begin
      @(negedge clock);
      #1;
      w++;
    end
    if (w >= 20) begin
      timeout = 1'b1;
      st_valid = 1'b0;
      key_valid = 1'b0;
      return;
    end
    @(posedge clock);
    #1;
    st_valid = 1'b0;
    key_valid = 1'b0;
    st_in = rand128();
    key_in = $urandom;
    do begin
      @(posedge clock);
      #1;
      lat++;
    end while (!out_valid && lat < 20);
    if (!out_valid) begin
      timeout = 1'b1;
      return;
    end
    d = out_data;
    di = out_data_i;
    k = out_is_key;
    @(negedge clock);
    out_ready = 1'b1;
    @(posedge clock);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    st_valid = 1'b1;
    key_valid = 1'b1;
    st_in = rand128();
    key_in = $urandom;
    out_ready = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    vectors++;
    if (out_valid !== 1'b0 || out_valid_i !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_out_valid got %b/%b want 0/0", out_valid, out_valid_i);
    end
    vectors++;
    if (out_data !== 128'h0 || out_data_i !== 128'h0) begin
      miscompares++;
      $display("[TB] FAIL reset_out_data got %h want 0", out_data);
    end
    vectors++;
    if (out_is_key !== 1'b0 || out_is_key_i !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_out_is_key got %b want 0", out_is_key);
    end
    vectors++;
    if ({st_ready, key_ready, st_ready_i, key_ready_i} !== 4'b0000) begin
      miscompares++;
      $display("[TB] FAIL reset_ready got %b want 0000",
               {st_ready, key_ready, st_ready_i, key_ready_i});
    end
    reset = 1'b0;
    st_valid = 1'b0;
    key_valid = 1'b0;
  endtask

  task automatic test_known_vectors();
    int lat;
    logic [127:0] d, di;
    logic k;
    bit to;
    applyStimulus(1'b0, 128'h00112233445566778899aabbccddeeff, lat, d, di, k, to);
    vectors++;
    if (to || lat !== 4) begin
      miscompares++;
      $display("[TB] FAIL known_state_latency got %0d want 4 (timeout=%0b)", lat, to);
    end
    vectors++;
    if (d !== 128'h638293c31bfc33f5c4eeacea4bc12816 || k !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL known_state_data got %h key=%b want 638293c31bfc33f5c4eeacea4bc12816 key=0", d, k);
    end
    applyStimulus(1'b1, {96'b0, 32'hcf4f3c09}, lat, d, di, k, to);
    vectors++;
    if (to || lat !== 1) begin
      miscompares++;
      $display("[TB] FAIL known_key_latency got %0d want 1 (timeout=%0b)", lat, to);
    end
    vectors++;
    if (d !== {96'b0, 32'h8a84eb01} || k !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL known_key_data got %h key=%b want 8a84eb01 key=1", d, k);
    end
    applyStimulus(1'b0, 128'h638293c31bfc33f5c4eeacea4bc12816, lat, d, di, k, to);
    vectors++;
    if (to || di !== 128'h00112233445566778899aabbccddeeff) begin
      miscompares++;
      $display("[TB] FAIL known_inverse_state got %h want 00112233445566778899aabbccddeeff", di);
    end
  endtask

  task automatic test_random();
    int lat;
    logic [127:0] d, di, x;
    logic k;
    bit to;
    for (int n = 0; n < 8; n++) begin
      x = rand128();
      applyStimulus(1'b0, x, lat, d, di, k, to);
      vectors++;
      if (to || lat !== 4 || k !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL rand_state_timing got lat=%0d key=%b want lat=4 key=0", lat, k);
      end
      vectors++;
      if (d !== exp_state(x, 1'b0) || di !== exp_state(x, 1'b1)) begin
        miscompares++;
        $display("[TB] FAIL rand_state_data in %h got %h/%h want %h/%h", x, d, di,
                 exp_state(x, 1'b0), exp_state(x, 1'b1));
      end
    end
    for (int n = 0; n < 8; n++) begin
      x = {96'b0, 32'($urandom)};
      applyStimulus(1'b1, x, lat, d, di, k, to);
      vectors++;
      if (to || lat !== 1 || k !== 1'b1) begin
        miscompares++;
        $display("[TB] FAIL rand_key_timing got lat=%0d key=%b want lat=1 key=1", lat, k);
      end
      vectors++;
      if (d !== exp_key(x[31:0], 1'b0) || di !== exp_key(x[31:0], 1'b1)) begin
        miscompares++;
        $display("[TB] FAIL rand_key_data in %h got %h/%h want %h/%h", x[31:0], d, di,
                 exp_key(x[31:0], 1'b0), exp_key(x[31:0], 1'b1));
      end
    end
  endtask

  // Both requesters held valid from a fresh reset: grants must alternate,
  // starting with the state requester.
  task automatic test_back_to_back();
    logic [127:0] s_data, exp_d, exp_di;
    logic [31:0]  k_data;
    bit last_was_key, grant_st;
    int w, lat;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    s_data = rand128();
    k_data = $urandom;
    st_valid = 1'b1;
    key_valid = 1'b1;
    st_in = s_data;
    key_in = k_data;
    out_ready = 1'b1;
    last_was_key = 1'b1;
    for (int g = 0; g < 4; g++) begin
      grant_st = last_was_key;
      #1;
      w = 0;
      while (!(st_ready || key_ready) && w < 20) begin
        @(negedge clock);
        #1;
        w++;
      end
      vectors++;
      if (st_ready !== grant_st || key_ready !== !grant_st) begin
        miscompares++;
        $display("[TB] FAIL rr_grant%0d got st=%b key=%b want st=%b key=%b",
                 g, st_ready, key_ready, grant_st, !grant_st);
      end
      exp_d  = grant_st ? exp_state(s_data, 1'b0) : exp_key(k_data, 1'b0);
      exp_di = grant_st ? exp_state(s_data, 1'b1) : exp_key(k_data, 1'b1);
      @(posedge clock);
      #1;
      if (grant_st) begin
        s_data = rand128();
        st_in = s_data;
      end else begin
        k_data = $urandom;
        key_in = k_data;
      end
      last_was_key = !grant_st;
      lat = 0;
      while (!out_valid && lat < 20) begin
        @(posedge clock);
        #1;
        lat++;
      end
      vectors++;
      if (out_valid !== 1'b1 || out_data !== exp_d || out_data_i !== exp_di ||
          out_is_key !== !grant_st) begin
        miscompares++;
        $display("[TB] FAIL rr_result%0d got v=%b %h key=%b want %h key=%b",
                 g, out_valid, out_data, out_is_key, exp_d, !grant_st);
      end
      vectors++;
      if (st_ready !== 1'b0 || key_ready !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL rr_done_ready%0d got st=%b key=%b want 0/0", g, st_ready, key_ready);
      end
      @(posedge clock);
      @(negedge clock);
    end
    st_valid = 1'b0;
    key_valid = 1'b0;
    out_ready = 1'b0;
  endtask

  task automatic checkOutput_hold_dummy();
  endtask

  task automatic test_hold();
    logic [127:0] x, d0;
    int lat;
    x = rand128();
    @(negedge clock);
    out_ready = 1'b0;
    st_valid = 1'b1;
    st_in = x;
    #1;
    lat = 0;
    while (!st_ready && lat < 20) begin
      @(negedge clock);
      #1;
      lat++;
    end
    @(posedge clock);
    #1;
    st_in = rand128();
    key_valid = 1'b1;
    key_in = $urandom;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clock);
      #1;
      lat++;
    end
    d0 = out_data;
    vectors++;
    if (out_valid !== 1'b1 || d0 !== exp_state(x, 1'b0)) begin
      miscompares++;
      $display("[TB] FAIL hold_result got v=%b %h want %h", out_valid, d0, exp_state(x, 1'b0));
    end
    for (int c = 0; c < 10; c++) begin
      @(posedge clock);
      #1;
      vectors++;
      if (out_valid !== 1'b1 || out_data !== d0 || st_ready !== 1'b0 || key_ready !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL hold_cycle%0d got v=%b %h rdy=%b%b want v=1 %h rdy=00",
                 c, out_valid, out_data, st_ready, key_ready, d0);
      end
    end
    @(negedge clock);
    out_ready = 1'b1;
    st_valid = 1'b0;
    key_valid = 1'b0;
    @(posedge clock);
    #1;
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL hold_release got out_valid=%b want 0", out_valid);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset_midop();
    logic [127:0] x, d, di;
    logic k;
    bit to, seen;
    int lat;
    x = rand128();
    @(negedge clock);
    out_ready = 1'b1;
    st_valid = 1'b1;
    st_in = x;
    #1;
    lat = 0;
    while (!st_ready && lat < 20) begin
      @(negedge clock);
      #1;
      lat++;
    end
    @(posedge clock);
    #1;
    st_valid = 1'b0;
    repeat (2) @(posedge clock);
    #2;
    reset = 1'b1;
    #1;
    vectors++;
    if (out_valid !== 1'b0 || out_data !== 128'h0) begin
      miscompares++;
      $display("[TB] FAIL midop_reset got v=%b %h want v=0 data=0", out_valid, out_data);
    end
    @(negedge clock);
    reset = 1'b0;
    seen = 1'b0;
    repeat (8) begin
      @(posedge clock);
      #1;
      if (out_valid) seen = 1'b1;
    end
    vectors++;
    if (seen !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL midop_discard got out_valid seen=%b want 0", seen);
    end
    x = rand128();
    applyStimulus(1'b0, x, lat, d, di, k, to);
    vectors++;
    if (to || lat !== 4 || d !== exp_state(x, 1'b0) || k !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL midop_recover got lat=%0d %h want lat=4 %h", lat, d, exp_state(x, 1'b0));
    end
  endtask

  initial begin
    reset = 1'b1;
    st_valid = 1'b0;
    key_valid = 1'b0;
    out_ready = 1'b0;
    st_in = '0;
    key_in = '0;
    build_tables();
    test_reset();
    test_known_vectors();
    test_random();
    test_back_to_back();
    test_hold();
    test_reset_midop();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
